msrv32_integer_file: RTL and testbench
======================================

# msrv32_integer_file

Integer register file for the msrv32 pipeline: the consumer of the write-back mux result. Captures the selected write-back word into x1–x31 on the clock edge and serves two combinational read ports to the decode/operand stage, with same-cycle write-to-read bypass. A per-register load scoreboard raises a hazard when an operand depends on a load that has not yet written back.

## Interface
- DATA_WIDTH, 32, register and port data width
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers, index 0 hard-wired to zero

Ports:
- ms_riscv32_mp_clk_in  input  1  single clock, all state updates on rising edge
- ms_riscv32_mp_rst_in  input  1  asynchronous, active-high reset
- rs_1_addr_in  input  5  read port 1 index
- rs_2_addr_in  input  5  read port 2 index
- rd_addr_in  input  5  write-back destination index
- wr_en_in  input  1  write-back request
- rd_in  input  32  write-back data (write-back mux output)
- flush_in  input  1  pipeline flush; suppresses write, clears scoreboard
- ld_issue_in  input  1  a load to ld_rd_addr_in is entering the pipe
- ld_rd_addr_in  input  5  load destination index
- rs_1_out  output  32  read data, port 1
- rs_2_out  output  32  read data, port 2
- hazard_out  output  1  an operand is pending on an outstanding load
- busy_vec_out  output  32  scoreboard bits, bit n = xn pending; bit 0 always 0

## Operation
- Qualified write: wr_q = wr_en_in & ~flush_in & (rd_addr_in != 0).
- On rising edge with wr_q: reg[rd_addr_in] <= rd_in. Otherwise all registers hold.
- x0: never written; reads of index 0 return 0 regardless of bypass.
- Read port k (k = 1, 2), combinational: if addr == 0 -> 0; else if wr_q and addr == rd_addr_in -> rd_in (bypass); else reg[addr].
- Scoreboard busy[31:1], next-state per index n:
  - flush_in = 1: busy[n] <= 0 for all n (overrides everything below).
  - else set_n = ld_issue_in & (ld_rd_addr_in == n); clr_n = wr_q & (rd_addr_in == n).
  - set_n -> 1 (set wins over simultaneous clear: new load to the same rd); else clr_n -> 0; else hold.
  - ld_issue_in with ld_rd_addr_in == 0: ignored.
- hazard_out, combinational: for each read port, addr != 0 & busy[addr] & ~(wr_q & rd_addr_in == addr); OR of both ports. A write-back landing this cycle resolves the hazard via the bypass.
- busy_vec_out = {busy[31:1], 1'b0}.
- Reset (asynchronous, any time, including mid-write): all registers 0, all busy bits 0 immediately; read outputs follow combinationally (0 unless bypass of an asserted wr_q). A write coincident with the reset-release edge is not captured if reset is still high at that edge.

## Timing
- Write latency: data on rd_in at edge t is readable from storage from t onward; in the cycle before edge t it is already visible through the bypass.
- Read latency: 0 cycles (combinational from addresses, rd_in, wr_en_in, flush_in).
- Scoreboard: set/clear take effect at the next edge; hazard_out reflects busy state plus the current-cycle write.
- No handshake back-pressure: the block always accepts a write; stalling is the pipeline controller's job using hazard_out.
- No combinational path from ld_issue_in to any output.

## Test plan
- Reset: assert ms_riscv32_mp_rst_in asynchronously between edges after writing x5 = 0xDEADBEEF -> rs_1_out (addr 5) = 0 immediately, busy_vec_out = 0, hazard_out = 0.
- Write/read and x0: write x7 = 0x12345678, x0 = 0xFFFFFFFF -> next cycle rs_1_out (7) = 0x12345678, rs_2_out (0) = 0; busy_vec_out bit 0 = 0.
- Bypass: same cycle wr_en_in = 1, rd_addr_in = 3, rd_in = 0xA5A5A5A5, rs_1_addr_in = rs_2_addr_in = 3, x3 stored = 0x1 -> both outputs 0xA5A5A5A5; with flush_in = 1 -> both 0x1 and x3 unchanged after edge.
- Scoreboard hazard: ld_issue_in to x10; next cycle rs_2_addr_in = 10 -> hazard_out = 1; write-back to x10 with 0x55 -> hazard_out = 0 that cycle, rs_2_out = 0x55, busy bit 10 clears after edge.
- Simultaneous set/clear: busy[4] = 1, same cycle wr_q to x4 and ld_issue_in to x4 -> after edge busy[4] = 1, x4 holds new data.
- Flush: busy bits 2, 9, 17 set, assert flush_in with wr_en_in = 1 to x2 -> after edge busy_vec_out = 0, x2 unchanged, hazard_out = 0.

Source files
------------

// File: rtl/msrv32_integer_file.sv
// Integer register file x0..x31 with two combinational read ports, same-cycle
// write-back bypass, and a per-register load scoreboard driving hazard_out.
module msrv32_integer_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       ms_riscv32_mp_clk_in,
  input  logic                       ms_riscv32_mp_rst_in,
  input  logic [ADDR_WIDTH-1:0]      rs_1_addr_in,
  input  logic [ADDR_WIDTH-1:0]      rs_2_addr_in,
  input  logic [ADDR_WIDTH-1:0]      rd_addr_in,
  input  logic                       wr_en_in,
  input  logic [DATA_WIDTH-1:0]      rd_in,
  input  logic                       flush_in,
  input  logic                       ld_issue_in,
  input  logic [ADDR_WIDTH-1:0]      ld_rd_addr_in,
  output logic [DATA_WIDTH-1:0]      rs_1_out,
  output logic [DATA_WIDTH-1:0]      rs_2_out,
  output logic                       hazard_out,
  output logic [(2**ADDR_WIDTH)-1:0] busy_vec_out
);
  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [NREG-1:0]       busy_q;
  logic [NREG-1:0]       busy_d;
  logic                  wr_qual;
  logic                  haz_1;
  logic                  haz_2;

  assign wr_qual = wr_en_in & ~flush_in & (rd_addr_in != '0);

  // Entry 0 is cleared by reset and never written, so it always reads 0.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_qual) begin
      regs_q[rd_addr_in] <= rd_in;
    end
  end

  // Load issue is applied after the write-back clear so a new load wins.
  always_comb begin
    busy_d = busy_q;
    if (flush_in) begin
      busy_d = '0;
    end else begin
      if (wr_qual) begin
        busy_d[rd_addr_in] = 1'b0;
      end
      if (ld_issue_in && (ld_rd_addr_in != '0)) begin
        busy_d[ld_rd_addr_in] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rs_1_out = regs_q[rs_1_addr_in];
    if (rs_1_addr_in == '0) begin
      rs_1_out = '0;
    end else if (wr_qual && (rs_1_addr_in == rd_addr_in)) begin
      rs_1_out = rd_in;
    end
  end

  always_comb begin
    rs_2_out = regs_q[rs_2_addr_in];
    if (rs_2_addr_in == '0) begin
      rs_2_out = '0;
    end else if (wr_qual && (rs_2_addr_in == rd_addr_in)) begin
      rs_2_out = rd_in;
    end
  end

  // A write-back landing this cycle resolves the dependency through the bypass.
  assign haz_1 = (rs_1_addr_in != '0) & busy_q[rs_1_addr_in]
               & ~(wr_qual & (rd_addr_in == rs_1_addr_in));
  assign haz_2 = (rs_2_addr_in != '0) & busy_q[rs_2_addr_in]
               & ~(wr_qual & (rd_addr_in == rs_2_addr_in));

  assign hazard_out   = haz_1 | haz_2;
  assign busy_vec_out = {busy_q[NREG-1:1], 1'b0};
endmodule

// File: tb/tb_msrv32_integer_file.sv
// Directed and randomized checks of the register file against an array model.
module tb_msrv32_integer_file;
  logic        clk;
  logic        rst;
  logic [4:0]  rs1_a, rs2_a, rd_a, ld_a;
  logic        wr_en, flush, ld_iss;
  logic [31:0] rd_d;
  logic [31:0] rs1_o, rs2_o, busy_o;
  logic        haz_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_reg [32];
  bit          m_busy [32];

  msrv32_integer_file dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .rs_1_addr_in         (rs1_a),
    .rs_2_addr_in         (rs2_a),
    .rd_addr_in           (rd_a),
    .wr_en_in             (wr_en),
    .rd_in                (rd_d),
    .flush_in             (flush),
    .ld_issue_in          (ld_iss),
    .ld_rd_addr_in        (ld_a),
    .rs_1_out             (rs1_o),
    .rs_2_out             (rs2_o),
    .hazard_out           (haz_o),
    .busy_vec_out         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_wr();
    return wr_en && !flush && rd_a != 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_wr() && a == rd_a) return rd_d;
    return m_reg[a];
  endfunction

  function automatic logic m_haz();
    logic h = 1'b0;
    if (rs1_a != 0 && m_busy[rs1_a] && !(m_wr() && rd_a == rs1_a)) h = 1'b1;
    if (rs2_a != 0 && m_busy[rs2_a] && !(m_wr() && rd_a == rs2_a)) h = 1'b1;
    return h;
  endfunction

  function automatic logic [31:0] m_busyvec();
    logic [31:0] v = '0;
    for (int n = 1; n < 32; n++) v[n] = m_busy[n];
    return v;
  endfunction

  task automatic m_clear();
    for (int n = 0; n < 32; n++) begin
      m_reg[n] = 32'h0;
      m_busy[n] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, ".rs1"}, rs1_o, m_read(rs1_a));
    chk({tag, ".rs2"}, rs2_o, m_read(rs2_a));
    chk({tag, ".haz"}, {31'h0, haz_o}, {31'h0, m_haz()});
    chk({tag, ".busy"}, busy_o, m_busyvec());
    $display("step %-10s rs1[%0d]=%h rs2[%0d]=%h haz=%0d busy=%h", tag, rs1_a, rs1_o, rs2_a, rs2_o, haz_o, busy_o);
  endtask

  // Check current outputs, cross the rising edge, update the model, park at negedge.
  task automatic step(input string tag);
    bit wq;
    check_all(tag);
    @(posedge clk);
    wq = m_wr();
    for (int n = 1; n < 32; n++) begin
      bit set_n, clr_n;
      set_n = ld_iss && ld_a == n;
      clr_n = wq && rd_a == n;
      if (flush) m_busy[n] = 1'b0;
      else if (set_n) m_busy[n] = 1'b1;
      else if (clr_n) m_busy[n] = 1'b0;
    end
    if (wq) m_reg[rd_a] = rd_d;
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 0; flush = 0; ld_iss = 0; rd_a = 0; ld_a = 0; rd_d = 0;
  endtask

  initial begin
    rst = 1'b1;
    rs1_a = 0; rs2_a = 0;
    idle();
    m_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Async reset after writing x5 and issuing a load to x6
    wr_en = 1; rd_a = 5; rd_d = 32'hDEADBEEF; ld_iss = 1; ld_a = 6;
    step("wr5");
    idle(); rs1_a = 5; rs2_a = 6;
    check_all("pre_rst");
    chk("pre_rst.x5", rs1_o, 32'hDEADBEEF);
    #1 rst = 1'b1;
    #1;
    m_clear();
    chk("rst.rs1", rs1_o, 32'h0);
    chk("rst.busy", busy_o, 32'h0);
    chk("rst.haz", {31'h0, haz_o}, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Write x7 then attempt x0
    wr_en = 1; rd_a = 7; rd_d = 32'h12345678;
    step("wr7");
    rd_a = 0; rd_d = 32'hFFFFFFFF; rs1_a = 7; rs2_a = 0;
    step("wr0");
    idle();
    check_all("rd7");
    chk("rd7.rs1", rs1_o, 32'h12345678);
    chk("rd7.rs2", rs2_o, 32'h0);
    chk("rd7.bit0", {31'h0, busy_o[0]}, 32'h0);

    // Bypass, then flush-suppressed bypass
    wr_en = 1; rd_a = 3; rd_d = 32'h1;
    step("wr3");
    rd_d = 32'hA5A5A5A5; rs1_a = 3; rs2_a = 3;
    check_all("byp");
    chk("byp.rs1", rs1_o, 32'hA5A5A5A5);
    chk("byp.rs2", rs2_o, 32'hA5A5A5A5);
    flush = 1;
    check_all("byp_fl");
    chk("byp_fl.rs1", rs1_o, 32'h1);
    step("byp_fl2");
    idle();
    check_all("x3_hold");
    chk("x3_hold.rs1", rs1_o, 32'h1);

    // Load scoreboard on x10
    ld_iss = 1; ld_a = 10;
    step("ld10");
    idle(); rs1_a = 0; rs2_a = 10;
    check_all("haz10");
    chk("haz10.haz", {31'h0, haz_o}, 32'h1);
    wr_en = 1; rd_a = 10; rd_d = 32'h55;
    check_all("wb10");
    chk("wb10.haz", {31'h0, haz_o}, 32'h0);
    chk("wb10.rs2", rs2_o, 32'h55);
    step("wb10s");
    idle();
    check_all("clr10");
    chk("clr10.bit", {31'h0, busy_o[10]}, 32'h0);

    // Simultaneous set and clear on x4
    ld_iss = 1; ld_a = 4;
    step("ld4");
    wr_en = 1; rd_a = 4; rd_d = 32'h44;
    step("setclr4");
    idle(); rs1_a = 4;
    check_all("after4");
    chk("after4.bit", {31'h0, busy_o[4]}, 32'h1);
    rs1_a = 0; rs2_a = 0;
    chk("after4.x4", m_reg[4], 32'h44);

    // Flush clears all pending loads and suppresses the write
    ld_iss = 1; ld_a = 2;  step("ld2");
    ld_a = 9;              step("ld9");
    ld_a = 17;             step("ld17");
    idle();
    flush = 1; wr_en = 1; rd_a = 2; rd_d = 32'h99;
    step("flush");
    idle(); rs1_a = 2; rs2_a = 9;
    check_all("postfl");
    chk("postfl.busy", busy_o, 32'h0);
    chk("postfl.haz", {31'h0, haz_o}, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      rs1_a  = 5'($urandom);
      rs2_a  = 5'($urandom);
      rd_a   = ($urandom_range(0, 3) == 0) ? rs1_a : 5'($urandom);
      wr_en  = 1'($urandom);
      rd_d   = $urandom;
      flush  = ($urandom_range(0, 15) == 0);
      ld_iss = 1'($urandom);
      ld_a   = ($urandom_range(0, 3) == 0) ? rs2_a : 5'($urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
